fetch_stage: RTL

//  IF stage of the 5-stage MIPS pipeline: owns the PC, selects next PC (seq/branch/jump), runs the
//  req/ack handshake to instruction memory and presents instr_f/pc_plus_4_f to the IF/ID register.

---
 rtl/fetch_stage_pkg.sv | 16 +
 rtl/fetch_stage_if.sv | 24 ++
 rtl/fetch_stage_pc_next_mux.sv | 26 ++
 rtl/fetch_stage.sv | 117 +++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the MIPS instruction-fetch stage.
package fetch_stage_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    // sll $0,$0,0
    localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        REQ     = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and imem.
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [XLEN-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_stage_pc_next_mux.sv
// Next-PC selection: sequential, branch or jump; jump has priority and targets are word-aligned.
module fetch_stage_pc_next_mux
    import fetch_stage_pkg::*;
(
    input  logic [XLEN-1:0] pc,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            jump,
    input  logic [XLEN-1:0] jump_target,
    output logic            redirect_c,
    output logic [XLEN-1:0] target_c,
    output logic [XLEN-1:0] seq_c,
    output logic [XLEN-1:0] next_pc_c
);

    always_comb begin
        redirect_c    = (jump | branch_taken) & ~stall;
        target_c      = jump ? jump_target : branch_target;
        target_c[1:0] = 2'b00;
        // Wraps modulo 2^32 from FFFF_FFFC to 0.
        seq_c         = pc + XLEN'(4);
        next_pc_c     = redirect_c ? target_c : seq_c;
    end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, runs the imem req/ack handshake and feeds the IF/ID register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_f,
    input  logic            branch_taken_d,
    input  logic [XLEN-1:0] branch_target_d,
    input  logic            jump_d,
    input  logic [XLEN-1:0] jump_target_d,
    fetch_stage_if.master   imem,
    output logic [XLEN-1:0] instr_f,
    output logic [XLEN-1:0] pc_f,
    output logic [XLEN-1:0] pc_plus_4_f,
    output logic            fetch_valid_f
);

    fetch_state_t    state;
    logic [XLEN-1:0] hold_buf;
    logic [XLEN-1:0] old_addr;

    logic            redirect_c;
    logic [XLEN-1:0] target_c;
    logic [XLEN-1:0] seq_c;
    logic [XLEN-1:0] next_pc_c;

    fetch_stage_pc_next_mux u_pc_next_mux (
        .pc            (pc_f),
        .stall         (stall_f),
        .branch_taken  (branch_taken_d),
        .branch_target (branch_target_d),
        .jump          (jump_d),
        .jump_target   (jump_target_d),
        .redirect_c    (redirect_c),
        .target_c      (target_c),
        .seq_c         (seq_c),
        .next_pc_c     (next_pc_c)
    );

    assign pc_plus_4_f = seq_c;

    // PC, fetch state and the buffers that survive stalls and redirects.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_f     <= RESET_PC;
            state    <= REQ;
            hold_buf <= NOP_INSTR;
            old_addr <= '0;
        end else begin
            case (state)
                REQ: begin
                    if (imem.imem_ack) begin
                        if (!stall_f) begin
                            pc_f <= next_pc_c;
                        end else begin
                            hold_buf <= imem.imem_rdata;
                            state    <= HOLD;
                        end
                    end else if (redirect_c) begin
                        // Outstanding request must stay on the bus until its ack arrives.
                        old_addr <= pc_f;
                        pc_f     <= target_c;
                        state    <= DISCARD;
                    end
                end
                HOLD: begin
                    if (!stall_f) begin
                        pc_f  <= next_pc_c;
                        state <= REQ;
                    end
                end
                DISCARD: begin
                    if (redirect_c) begin
                        pc_f <= target_c;
                    end
                    if (imem.imem_ack) begin
                        state <= REQ;
                    end
                end
                default: state <= REQ;
            endcase
        end
    end

    // Bus and IF/ID outputs; an ack in REQ is forwarded in the same cycle.
    always_comb begin
        imem.imem_req  = 1'b0;
        imem.imem_addr = pc_f;
        fetch_valid_f  = 1'b0;
        instr_f        = NOP_INSTR;
        if (!rst) begin
            case (state)
                REQ: begin
                    imem.imem_req = 1'b1;
                    if (imem.imem_ack) begin
                        fetch_valid_f = 1'b1;
                        instr_f       = imem.imem_rdata;
                    end
                end
                HOLD: begin
                    fetch_valid_f = 1'b1;
                    instr_f       = hold_buf;
                end
                DISCARD: begin
                    imem.imem_req  = 1'b1;
                    imem.imem_addr = old_addr;
                end
                default: ;
            endcase
        end
    end

endmodule
